// File: rtl/pcounter_pkg.sv
// Register map, CTRL layout and helpers shared by the multi-channel performance counter.
package pcounter_pkg;

  // Register offsets within a channel window (addr[1:0])
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegCount  = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegGlobal = 2'd3;

  // CTRL / STATUS / GLOBAL bit positions
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlSatBit   = 1;
  localparam int unsigned CtrlModeLsb  = 2;
  localparam int unsigned CtrlIrqEnBit = 4;
  localparam int unsigned CtrlSelLsb   = 8;
  localparam int unsigned StatusOvfBit = 0;
  localparam int unsigned GlobalEnBit  = 0;
  localparam int unsigned GlobalClrBit = 1;

  typedef enum logic [1:0] {
    PC_LEVEL = 2'b00,
    PC_EDGE  = 2'b01,
    PC_CYCLE = 2'b10,
    PC_RSVD  = 2'b11
  } pc_mode_e;

  // evt_sel is sized for the largest event count; unused upper bits are held at zero
  typedef struct packed {
    logic [7:0] evt_sel;
    logic       irq_en;
    pc_mode_e   mode;
    logic       sat;
    logic       en;
  } pc_ctrl_t;

  function automatic logic [15:0] ctrl_to_word(pc_ctrl_t c);
    logic [15:0] w;
    w                        = '0;
    w[CtrlEnBit]             = c.en;
    w[CtrlSatBit]            = c.sat;
    w[CtrlModeLsb +: 2]      = c.mode;
    w[CtrlIrqEnBit]          = c.irq_en;
    w[CtrlSelLsb +: 8]       = c.evt_sel;
    return w;
  endfunction

endpackage

// File: rtl/pcounter_chan.sv
// One counter channel: CTRL/COUNT/ovf state, event edge history and increment/saturate/wrap.
module pcounter_chan import pcounter_pkg::*; #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_EV = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_EV-1:0] evt_i,
  input  logic              genable_i,
  input  logic              clear_all_i,
  input  logic              ctrl_we_i,
  input  pc_ctrl_t          ctrl_wdata_i,
  input  logic              count_we_i,
  input  logic [CNT_W-1:0]  count_wdata_i,
  input  logic              ovf_clr_i,
  output pc_ctrl_t          ctrl_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  localparam int unsigned SEL_W = $clog2(NUM_EV);

  pc_ctrl_t           ctrl_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               evt_prev_q;
  logic [SEL_W-1:0]   sel;
  logic               evt_cur, mode_hit, inc, at_max;

  assign sel     = ctrl_q.evt_sel[SEL_W-1:0];
  assign evt_cur = evt_i[sel];
  assign at_max  = &count_q;

  always_comb begin
    mode_hit = 1'b0;
    unique case (ctrl_q.mode)
      PC_LEVEL: mode_hit = evt_cur;
      PC_EDGE:  mode_hit = evt_cur & ~evt_prev_q;
      PC_CYCLE: mode_hit = 1'b1;
      default:  mode_hit = 1'b0;
    endcase
  end

  assign inc = genable_i & ctrl_q.en & mode_hit;

  // clear_all beats a bus write, which beats an increment; a new overflow beats W1C
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_all_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
      if (count_we_i) begin
        count_d = count_wdata_i;
      end else if (inc) begin
        if (at_max) begin
          count_d = ctrl_q.sat ? count_q : '0;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      evt_prev_q <= 1'b0;
    end else begin
      if (ctrl_we_i) begin
        ctrl_q <= ctrl_wdata_i;
      end
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      evt_prev_q <= evt_cur;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pcounter_multi.sv
// Multi-channel performance counter: cfg bus decode, GLOBAL register, read mux and overflow IRQ.
module pcounter_multi import pcounter_pkg::*; #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_EV = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_EV-1:0] evt,
  input  logic              cfg_enable_sig,
  input  logic              cfg_rd_wr_sig,
  input  logic [ADDR_W-1:0] cfg_addr_sig,
  input  logic [DATA_W-1:0] cfg_wdata_sig,
  output logic [DATA_W-1:0] cfg_rdata_sig,
  output logic              cfg_rvalid_sig,
  output logic              irq
);

  localparam int unsigned CH_W    = ADDR_W - 2;
  localparam int unsigned SEL_W   = $clog2(NUM_EV);
  localparam logic [7:0]  SelMask = 8'((1 << SEL_W) - 1);

  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_sel;
  logic              ch_valid, wr_en, rd_en, global_wr, clear_all;
  pc_ctrl_t          wr_ctrl;
  logic              genable_q;
  logic [DATA_W-1:0] rd_word, rdata_q;
  logic              rvalid_q, irq_q;

  pc_ctrl_t          ch_ctrl  [NUM_CH];
  logic [CNT_W-1:0]  ch_count [NUM_CH];
  logic [NUM_CH-1:0] ch_ovf, irq_src;

  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_sig;

  assign ch_idx   = cfg_addr_sig[ADDR_W-1:2];
  assign reg_sel  = cfg_addr_sig[1:0];
  assign ch_valid = 32'(ch_idx) < NUM_CH;
  // Out-of-range channel writes are dropped, GLOBAL included
  assign wr_en    = cfg_enable_sig & cfg_rd_wr_sig & ch_valid;
  assign rd_en    = cfg_enable_sig & ~cfg_rd_wr_sig;

  assign global_wr = wr_en & (reg_sel == RegGlobal);
  assign clear_all = global_wr & cfg_wdata_sig[GlobalClrBit];

  always_comb begin
    wr_ctrl         = '0;
    wr_ctrl.en      = cfg_wdata_sig[CtrlEnBit];
    wr_ctrl.sat     = cfg_wdata_sig[CtrlSatBit];
    wr_ctrl.mode    = pc_mode_e'(cfg_wdata_sig[CtrlModeLsb +: 2]);
    wr_ctrl.irq_en  = cfg_wdata_sig[CtrlIrqEnBit];
    wr_ctrl.evt_sel = cfg_wdata_sig[CtrlSelLsb +: 8] & SelMask;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    logic ch_hit;
    assign ch_hit = wr_en & (ch_idx == CH_W'(c));

    pcounter_chan #(
      .CNT_W (CNT_W),
      .NUM_EV(NUM_EV)
    ) u_chan (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .evt_i        (evt),
      .genable_i    (genable_q),
      .clear_all_i  (clear_all),
      .ctrl_we_i    (ch_hit & (reg_sel == RegCtrl)),
      .ctrl_wdata_i (wr_ctrl),
      .count_we_i   (ch_hit & (reg_sel == RegCount)),
      .count_wdata_i(cfg_wdata_sig[CNT_W-1:0]),
      .ovf_clr_i    (ch_hit & (reg_sel == RegStatus) & cfg_wdata_sig[StatusOvfBit]),
      .ctrl_o       (ch_ctrl[c]),
      .count_o      (ch_count[c]),
      .ovf_o        (ch_ovf[c])
    );

    assign irq_src[c] = ch_ovf[c] & ch_ctrl[c].irq_en;
  end

  // clear_all is write-only and never stored, so GLOBAL reads back genable alone
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == CH_W'(c)) begin
        case (reg_sel)
          RegCtrl:   rd_word = DATA_W'(ctrl_to_word(ch_ctrl[c]));
          RegCount:  rd_word = DATA_W'(ch_count[c]);
          RegStatus: rd_word = DATA_W'(ch_ovf[c]);
          default:   rd_word = DATA_W'(genable_q);
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      genable_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (global_wr) begin
        genable_q <= cfg_wdata_sig[GlobalEnBit];
      end
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_word;
      end
      irq_q <= |irq_src;
    end
  end

  assign cfg_rdata_sig  = rdata_q;
  assign cfg_rvalid_sig = rvalid_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_pcounter_multi.sv
// Directed bench for pcounter_multi (4 channels, 8-bit counters) with immediate-assertion checks.
module tb_pcounter_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_EV = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NUM_EV-1:0] evt;
  logic              cfg_enable_sig;
  logic              cfg_rd_wr_sig;
  logic [ADDR_W-1:0] cfg_addr_sig;
  logic [DATA_W-1:0] cfg_wdata_sig;
  logic [DATA_W-1:0] cfg_rdata_sig;
  logic              cfg_rvalid_sig;
  logic              irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_data;
  logic        rd_valid;

  pcounter_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .NUM_EV(NUM_EV),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .evt           (evt),
    .cfg_enable_sig(cfg_enable_sig),
    .cfg_rd_wr_sig (cfg_rd_wr_sig),
    .cfg_addr_sig  (cfg_addr_sig),
    .cfg_wdata_sig (cfg_wdata_sig),
    .cfg_rdata_sig (cfg_rdata_sig),
    .cfg_rvalid_sig(cfg_rvalid_sig),
    .irq           (irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe sampled on the posedge between the two negedges
  task automatic wr(input int ch, input int r, input logic [31:0] data);
    @(negedge Clk);
    cfg_enable_sig = 1'b1;
    cfg_rd_wr_sig  = 1'b1;
    cfg_addr_sig   = {ch[3:0], r[1:0]};
    cfg_wdata_sig  = data;
    @(negedge Clk);
    cfg_enable_sig = 1'b0;
    cfg_rd_wr_sig  = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] data, output logic valid);
    @(negedge Clk);
    cfg_enable_sig = 1'b1;
    cfg_rd_wr_sig  = 1'b0;
    cfg_addr_sig   = {ch[3:0], r[1:0]};
    @(negedge Clk);
    cfg_enable_sig = 1'b0;
    data  = cfg_rdata_sig;
    valid = cfg_rvalid_sig;
  endtask

  // Write strobe immediately followed by a read strobe of the same register
  task automatic wr_rd(input int ch, input int r, input logic [31:0] wdata,
                       output logic [31:0] data, output logic valid);
    wr(ch, r, wdata);
    cfg_enable_sig = 1'b1;
    cfg_addr_sig   = {ch[3:0], r[1:0]};
    @(negedge Clk);
    cfg_enable_sig = 1'b0;
    data  = cfg_rdata_sig;
    valid = cfg_rvalid_sig;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    rd(ch, r, d, v);
    check({tag, "_rvalid"}, {31'b0, v}, 32'd1);
    check(tag, d, exp);
  endtask

  initial begin
    Rst            = 1'b1;
    evt            = '0;
    cfg_enable_sig = 1'b0;
    cfg_rd_wr_sig  = 1'b0;
    cfg_addr_sig   = '0;
    cfg_wdata_sig  = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // Reset state and full register sweep
    check("rst_rdata", cfg_rdata_sig, 32'd0);
    check("rst_rvalid", {31'b0, cfg_rvalid_sig}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      for (int r = 0; r < 4; r++) begin
        rd_chk($sformatf("t1_ch%0d_r%0d", ch, r), ch, r, 32'd0);
      end
    end
    @(negedge Clk);
    check("t1_rvalid_pulse", {31'b0, cfg_rvalid_sig}, 32'd0);
    rd_chk("t1_oob_read", 5, 1, 32'd0);

    // Level mode on evt[3] for 10 cycles
    wr(0, 0, 32'h301);
    wr(0, 3, 32'h1);
    @(negedge Clk);
    evt[3] = 1'b1;
    repeat (10) @(negedge Clk);
    evt[3] = 1'b0;
    rd_chk("t2_level", 0, 1, 32'd10);
    rd_chk("t2_ctrl", 0, 0, 32'h301);

    // Edge mode: four 2-cycle pulses
    wr(0, 1, 32'h0);
    wr(0, 0, 32'h305);
    for (int p = 0; p < 4; p++) begin
      @(negedge Clk);
      evt[3] = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      evt[3] = 1'b0;
      @(negedge Clk);
    end
    rd_chk("t2_edge", 0, 1, 32'd4);
    wr(0, 0, 32'h0);

    // Wrap on ch1 with IRQ
    wr(1, 1, 32'hFE);
    wr(1, 0, 32'h19);
    @(negedge Clk);
    check("t3_irq_pre", {31'b0, irq}, 32'd0);
    rd_chk("t3_wrap", 1, 1, 32'h00);
    check("t3_irq_set", {31'b0, irq}, 32'd1);
    rd_chk("t3_ovf", 1, 2, 32'd1);
    wr(1, 2, 32'h1);
    check("t3_irq_hold", {31'b0, irq}, 32'd1);
    @(negedge Clk);
    check("t3_irq_clr", {31'b0, irq}, 32'd0);
    rd_chk("t3_ovf_clr", 1, 2, 32'd0);

    // Saturation on ch1
    wr(1, 0, 32'h0);
    wr(1, 1, 32'hFE);
    wr(1, 0, 32'h1B);
    repeat (3) @(negedge Clk);
    rd_chk("t3_sat", 1, 1, 32'hFF);
    rd_chk("t3_sat_ovf", 1, 2, 32'd1);
    check("t3_sat_irq", {31'b0, irq}, 32'd1);

    // W1C racing a new overflow: the set wins
    wr_rd(1, 2, 32'h1, rd_data, rd_valid);
    check("t4_w1c_race_rvalid", {31'b0, rd_valid}, 32'd1);
    check("t4_w1c_race", rd_data, 32'd1);
    wr(1, 0, 32'h0);
    wr(1, 2, 32'h1);
    rd_chk("t4_ovf_clr", 1, 2, 32'd0);
    check("t4_irq_clr", {31'b0, irq}, 32'd0);

    // COUNT write while counting every cycle
    wr(2, 0, 32'h9);
    repeat (5) @(negedge Clk);
    wr_rd(2, 1, 32'h55, rd_data, rd_valid);
    check("t4_cwr_rvalid", {31'b0, rd_valid}, 32'd1);
    check("t4_cwr_now", rd_data, 32'h55);
    repeat (3) @(negedge Clk);
    rd_chk("t4_cwr_later", 2, 1, 32'h5A);

    // clear_all while all four channels count
    wr(0, 0, 32'h9);
    wr(1, 0, 32'h9);
    wr(3, 1, 32'hFF);
    wr(3, 0, 32'h9);
    rd_chk("t5_ovf_pre", 3, 2, 32'd1);
    wr(0, 3, 32'h3);
    rd_chk("t5_c0", 0, 1, 32'd1);
    rd_chk("t5_c1", 1, 1, 32'd3);
    rd_chk("t5_c2", 2, 1, 32'd5);
    rd_chk("t5_c3", 3, 1, 32'd7);
    rd_chk("t5_ovf3", 3, 2, 32'd0);
    rd_chk("t5_ctrl2", 2, 0, 32'h9);
    rd_chk("t5_global", 0, 3, 32'h1);
    rd_chk("t5_oob", 7, 1, 32'd0);

    // Reset during counting with a read strobe in the same cycle
    wr(0, 0, 32'h19);
    wr(0, 1, 32'hFF);
    repeat (3) @(negedge Clk);
    check("t6_irq_pre", {31'b0, irq}, 32'd1);
    rd_chk("t6_ctrl_pre", 0, 0, 32'h19);
    @(negedge Clk);
    cfg_enable_sig = 1'b1;
    cfg_rd_wr_sig  = 1'b0;
    cfg_addr_sig   = {4'd0, 2'd1};
    Rst            = 1'b1;
    @(negedge Clk);
    cfg_enable_sig = 1'b0;
    Rst            = 1'b0;
    check("t6_rvalid", {31'b0, cfg_rvalid_sig}, 32'd0);
    check("t6_rdata", cfg_rdata_sig, 32'd0);
    check("t6_irq", {31'b0, irq}, 32'd0);
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      for (int r = 0; r < 4; r++) begin
        rd_chk($sformatf("t6_ch%0d_r%0d", ch, r), ch, r, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
